alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential execution unit: single-cycle ALU ops finish in one step, while mul/divu/remu
// iterate one bit per cycle. Operands and results move through valid/ready handshakes.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [3:0]      alu_op_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic            zero_o,
    output logic            busy_o
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_ANDL = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   quick_res;
    logic              is_multi;
    logic [2*XLEN-1:0] mul_acc_nxt;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_nxt;
    logic [XLEN-1:0]   div_quo_nxt;

    assign shamt    = src2_i[SHW-1:0];
    assign is_multi = (alu_op_i == OP_MUL) || (alu_op_i == OP_DIVU) || (alu_op_i == OP_REMU);

    always_comb begin
        quick_res = '0;
        case (alu_op_i)
            OP_ADD:         quick_res = src1_i + src2_i;
            OP_SUB:         quick_res = src1_i - src2_i;
            OP_AND,
            OP_ANDL:        quick_res = src1_i & src2_i;
            OP_OR:          quick_res = src1_i | src2_i;
            OP_XOR:         quick_res = src1_i ^ src2_i;
            OP_SRL:         quick_res = src1_i >> shamt;
            OP_SRA:         quick_res = $signed(src1_i) >>> shamt;
            OP_SLL:         quick_res = src1_i << shamt;
            OP_SLT:         quick_res = {{(XLEN-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            OP_SLTU:        quick_res = {{(XLEN-1){1'b0}}, src1_i < src2_i};
            default:        quick_res = '0;
        endcase
    end

    // mul: a_q holds the multiplier shifting right, mcand_q the multiplicand shifting left.
    // div: acc_q low half is the partial remainder, a_q shifts dividend bits out and quotient bits in.
    // A zero divisor naturally yields all-ones quotient and the dividend as remainder.
    assign mul_acc_nxt = a_q[0] ? acc_q + mcand_q : acc_q;
    assign div_trial   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    assign div_ge      = div_trial >= {1'b0, b_q};
    assign div_rem_nxt = div_ge ? div_trial[XLEN-1:0] - b_q : div_trial[XLEN-1:0];
    assign div_quo_nxt = {a_q[XLEN-2:0], div_ge};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    op_d    = alu_op_i;
                    a_d     = src1_i;
                    b_d     = src2_i;
                    mcand_d = {{XLEN{1'b0}}, src2_i};
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (is_multi) begin
                        state_d = BUSY;
                    end else begin
                        result_d = quick_res;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d   = mul_acc_nxt;
                    mcand_d = mcand_q << 1;
                    a_d     = a_q >> 1;
                end else begin
                    acc_d = {{XLEN{1'b0}}, div_rem_nxt};
                    a_d   = div_quo_nxt;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MUL:  result_d = mul_acc_nxt[XLEN-1:0];
                        OP_DIVU: result_d = div_quo_nxt;
                        default: result_d = div_rem_nxt;
                    endcase
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over accept and handshake, and leaves the visible result untouched.
        if (flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o   = (state_q == IDLE);
    assign out_valid_o  = (state_q == DONE);
    assign busy_o       = (state_q == BUSY);
    assign alu_result_o = result_q;
    assign zero_o       = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and randomized ops at XLEN=32 and XLEN=8,
// compared against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic        sel8;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  aluOp;

    logic        inReady32, outValid32, zero32, busy32;
    logic [31:0] result32;
    logic        inReady8, outValid8, zero8, busy8;
    logic [7:0]  result8;

    logic        inReadyM, outValidM, zeroM, busyM;
    logic [31:0] resultM;

    int checks = 0;
    int failures = 0;
    int xferCount = 0;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid & ~sel8), .in_ready_o(inReady32),
        .src1_i(src1), .src2_i(src2), .alu_op_i(aluOp),
        .out_valid_o(outValid32), .out_ready_i(outReady),
        .alu_result_o(result32), .zero_o(zero32), .busy_o(busy32)
    );

    alu_seq #(.XLEN(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid & sel8), .in_ready_o(inReady8),
        .src1_i(src1[7:0]), .src2_i(src2[7:0]), .alu_op_i(aluOp),
        .out_valid_o(outValid8), .out_ready_i(outReady),
        .alu_result_o(result8), .zero_o(zero8), .busy_o(busy8)
    );

    assign inReadyM  = sel8 ? inReady8  : inReady32;
    assign outValidM = sel8 ? outValid8 : outValid32;
    assign zeroM     = sel8 ? zero8     : zero32;
    assign busyM     = sel8 ? busy8     : busy32;
    assign resultM   = sel8 ? {24'd0, result8} : result32;

    // Consumer-side transfer counter.
    always @(posedge clk) begin
        if (outValidM && outReady && !flush && !rst) xferCount <= xferCount + 1;
    end

    // Reference behaviour computed from the op definitions with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] aIn,
                                          input logic [31:0] bIn, input int w);
        longint unsigned mask, a, b, sh, r;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = aIn & mask;
        b = bIn & mask;
        sh = b % longint'(w);
        sa = ((a >> (w-1)) != 0) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb = ((b >> (w-1)) != 0) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        case (op)
            4'd0:        r = a + b;
            4'd1:        r = a - b;
            4'd2, 4'd10: r = a & b;
            4'd3:        r = a | b;
            4'd4:        r = a ^ b;
            4'd5:        r = a >> sh;
            4'd6:        r = longint'(sa >>> sh);
            4'd7:        r = a << sh;
            4'd8:        r = (sa < sb) ? 1 : 0;
            4'd9:        r = (a < b) ? 1 : 0;
            4'd12:       r = a * b;
            4'd14:       r = (b == 0) ? mask : a / b;
            4'd15:       r = (b == 0) ? a : a % b;
            default:     r = 0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int expLat(input logic [3:0] op, input int w);
        return (op == 4'd12 || op == 4'd14 || op == 4'd15) ? w + 1 : 1;
    endfunction

    // Drives one op with out_ready held high; reports result, latency in cycles from the
    // accept edge, busy cycles, and the handshake outputs one cycle after the result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic zeroObs, output int lat,
                         output int bcnt, output logic ovAfter, output logic irAfter);
        src1 = a;
        src2 = b;
        aluOp = op;
        inValid = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        aluOp = 4'($urandom);
        lat = 1;
        bcnt = 0;
        while (!outValidM && lat < 100) begin
            if (busyM) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = resultM;
        zeroObs = zeroM;
        @(posedge clk);
        #1;
        ovAfter = outValidM;
        irAfter = inReadyM;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        sel8 = 1'b0;
        src1 = '0;
        src2 = '0;
        aluOp = '0;
        #23;
        checks += 5;
        if (inReadyM !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReadyM); end
        if (outValidM !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValidM); end
        if (busyM !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busyM); end
        if (resultM !== 32'd0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", resultM); end
        if (zeroM !== 1'b1) begin failures++; $display("[TB] FAIL reset_zero got=%b exp=1", zeroM); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [3:0]  ops [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd9};
        logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [5] = '{32'd1, 32'd7, 32'd4, 32'd1, 32'd1};
        logic [31:0] exs [5] = '{32'h0, 32'hFFFFFFFE, 32'hF8000000, 32'd1, 32'd0};
        logic [31:0] res;
        logic z, ova, ira;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], res, z, lat, bc, ova, ira);
            checks += 5;
            if (res !== exs[i]) begin failures++; $display("[TB] FAIL basic_result op=%0d got=%h exp=%h", ops[i], res, exs[i]); end
            if (z !== (exs[i] == 32'd0)) begin failures++; $display("[TB] FAIL basic_zero op=%0d got=%b exp=%b", ops[i], z, exs[i] == 32'd0); end
            if (lat != 1) begin failures++; $display("[TB] FAIL basic_latency op=%0d got=%0d exp=1", ops[i], lat); end
            if (ova !== 1'b0) begin failures++; $display("[TB] FAIL basic_one_cycle_valid op=%0d got=%b exp=0", ops[i], ova); end
            if (ira !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_after op=%0d got=%b exp=1", ops[i], ira); end
        end
    endtask

    task automatic test_random_single();
        logic [31:0] a, b, res, ex;
        logic [3:0] op;
        logic z, ova, ira;
        int k, lat, bc;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 12);
            op = (k == 12) ? 4'd13 : 4'(k);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ex = model(op, a, b, 32);
            do_op(op, a, b, res, z, lat, bc, ova, ira);
            checks += 3;
            if (res !== ex) begin failures++; $display("[TB] FAIL rand_single op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, ex); end
            if (lat != 1) begin failures++; $display("[TB] FAIL rand_single_latency op=%0d got=%0d exp=1", op, lat); end
            if (ova !== 1'b0) begin failures++; $display("[TB] FAIL rand_single_valid_after op=%0d got=%b exp=0", op, ova); end
        end
    endtask

    task automatic test_multi();
        logic [3:0]  ops [7] = '{4'd12, 4'd14, 4'd15, 4'd14, 4'd15, 4'd11, 4'd13};
        logic [31:0] as  [7] = '{32'h00010001, 32'd100, 32'd100, 32'hDEADBEEF, 32'd123, 32'hFFFF, 32'h1234};
        logic [31:0] bs  [7] = '{32'h00010001, 32'd7, 32'd7, 32'd0, 32'd0, 32'h1, 32'h5678};
        logic [31:0] exs [7] = '{32'h00020001, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd123, 32'd0, 32'd0};
        logic [31:0] a, b, res, ex;
        logic [3:0] op;
        logic z, ova, ira;
        int k, lat, bc;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], res, z, lat, bc, ova, ira);
            checks += 4;
            if (res !== exs[i]) begin failures++; $display("[TB] FAIL multi_result op=%0d got=%h exp=%h", ops[i], res, exs[i]); end
            if (z !== (exs[i] == 32'd0)) begin failures++; $display("[TB] FAIL multi_zero op=%0d got=%b exp=%b", ops[i], z, exs[i] == 32'd0); end
            if (lat != expLat(ops[i], 32)) begin failures++; $display("[TB] FAIL multi_latency op=%0d got=%0d exp=%0d", ops[i], lat, expLat(ops[i], 32)); end
            if (bc != expLat(ops[i], 32) - 1) begin failures++; $display("[TB] FAIL multi_busy_cycles op=%0d got=%0d exp=%0d", ops[i], bc, expLat(ops[i], 32) - 1); end
        end
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 2);
            op = (k == 0) ? 4'd12 : ((k == 1) ? 4'd14 : 4'd15);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            ex = model(op, a, b, 32);
            do_op(op, a, b, res, z, lat, bc, ova, ira);
            checks += 2;
            if (res !== ex) begin failures++; $display("[TB] FAIL rand_multi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, ex); end
            if (lat != 33) begin failures++; $display("[TB] FAIL rand_multi_latency op=%0d got=%0d exp=33", op, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ex;
        int x0;
        src1 = 32'h1234;
        src2 = 32'h1111;
        aluOp = 4'd0;
        ex = model(4'd0, 32'h1234, 32'h1111, 32);
        outReady = 1'b0;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks += 3;
            if (outValidM !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_hold cyc=%0d got=%b exp=1", i, outValidM); end
            if (resultM !== ex) begin failures++; $display("[TB] FAIL bp_result_hold cyc=%0d got=%h exp=%h", i, resultM, ex); end
            if (inReadyM !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b exp=0", i, inReadyM); end
            src1 = $urandom;
            src2 = $urandom;
            aluOp = 4'd12;
            inValid = 1'b1;
            @(posedge clk);
            #1;
            inValid = 1'b0;
        end
        x0 = xferCount;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (outValidM !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid got=%b exp=0", outValidM); end
        if (inReadyM !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%b exp=1", inReadyM); end
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (xferCount - x0 != 1) begin failures++; $display("[TB] FAIL bp_transfer_count got=%0d exp=1", xferCount - x0); end
        if (busyM !== 1'b0 || outValidM !== 1'b0) begin failures++; $display("[TB] FAIL bp_pulses_ignored busy=%b valid=%b exp=0,0", busyM, outValidM); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic z, ova, ira, seen;
        int lat, bc, x0;
        src1 = 32'd1000;
        src2 = 32'd7;
        aluOp = 4'd14;
        outReady = 1'b1;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks += 2;
        if (inReadyM !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy_to_idle got=%b exp=1", inReadyM); end
        if (busyM !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy_clear got=%b exp=0", busyM); end
        x0 = xferCount;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (outValidM) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_valid got=%b exp=0", seen); end
        if (xferCount != x0) begin failures++; $display("[TB] FAIL flush_no_transfer got=%0d exp=%0d", xferCount, x0); end
        do_op(4'd0, 32'd2, 32'd3, res, z, lat, bc, ova, ira);
        checks += 1;
        if (res !== 32'd5) begin failures++; $display("[TB] FAIL flush_followup_add got=%h exp=5", res); end
        // flush and out_ready together while a result is held
        src1 = 32'd7;
        src2 = 32'd8;
        aluOp = 4'd0;
        outReady = 1'b0;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checks += 1;
        if (outValidM !== 1'b1) begin failures++; $display("[TB] FAIL flush_done_reached got=%b exp=1", outValidM); end
        flush = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks += 3;
        if (outValidM !== 1'b0) begin failures++; $display("[TB] FAIL flush_done_valid got=%b exp=0", outValidM); end
        if (inReadyM !== 1'b1) begin failures++; $display("[TB] FAIL flush_done_ready got=%b exp=1", inReadyM); end
        if (resultM !== 32'd15) begin failures++; $display("[TB] FAIL flush_result_kept got=%h exp=f", resultM); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic z, ova, ira;
        int lat, bc;
        src1 = $urandom | 32'h1;
        src2 = $urandom | 32'h1;
        aluOp = 4'd12;
        outReady = 1'b1;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks += 1;
        if (busyM !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_busy got=%b exp=1", busyM); end
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (inReadyM !== 1'b1) begin failures++; $display("[TB] FAIL areset_in_ready got=%b exp=1", inReadyM); end
        if (busyM !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy got=%b exp=0", busyM); end
        if (resultM !== 32'd0) begin failures++; $display("[TB] FAIL areset_result got=%h exp=0", resultM); end
        if (zeroM !== 1'b1) begin failures++; $display("[TB] FAIL areset_zero got=%b exp=1", zeroM); end
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(4'd12, 32'd3, 32'd4, res, z, lat, bc, ova, ira);
        checks += 2;
        if (res !== 32'd12) begin failures++; $display("[TB] FAIL areset_mul got=%h exp=c", res); end
        if (lat != 33) begin failures++; $display("[TB] FAIL areset_mul_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_xlen8();
        logic [31:0] a, b, res, ex;
        logic [3:0] op;
        logic z, ova, ira;
        int k, lat, bc;
        sel8 = 1'b1;
        do_op(4'd12, 32'd15, 32'd17, res, z, lat, bc, ova, ira);
        checks += 3;
        if (res !== 32'hFF) begin failures++; $display("[TB] FAIL x8_mul got=%h exp=ff", res); end
        if (lat != 9) begin failures++; $display("[TB] FAIL x8_mul_latency got=%0d exp=9", lat); end
        if (bc != 8) begin failures++; $display("[TB] FAIL x8_mul_busy got=%0d exp=8", bc); end
        do_op(4'd14, 32'd200, 32'd3, res, z, lat, bc, ova, ira);
        checks += 2;
        if (res !== 32'd66) begin failures++; $display("[TB] FAIL x8_divu got=%h exp=42", res); end
        if (lat != 9) begin failures++; $display("[TB] FAIL x8_divu_latency got=%0d exp=9", lat); end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 14);
            op = (k == 14) ? 4'd15 : 4'(k);
            a = 32'($urandom_range(0, 255));
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            ex = model(op, a, b, 8);
            do_op(op, a, b, res, z, lat, bc, ova, ira);
            checks += 2;
            if (res !== ex) begin failures++; $display("[TB] FAIL x8_rand op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, ex); end
            if (lat != expLat(op, 8)) begin failures++; $display("[TB] FAIL x8_rand_latency op=%0d got=%0d exp=%0d", op, lat, expLat(op, 8)); end
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_single();
        test_multi();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_xlen8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
